// File: rtl/step_sequencer.sv
// 16-step pattern sequencer: tick divider, gated note output, restart/stop control.
// Define SEQ_PINGPONG_EN to make the step bounce between the end steps instead of wrapping.
module step_sequencer #(
  parameter int unsigned TICK_W = 16,
  parameter int unsigned NOTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [TICK_W-1:0] tick_div,
  input  logic [TICK_W-1:0] gate_len,
  input  logic [3:0]        len_m1,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic              wr_on,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic [3:0]        step,
  output logic              step_strobe,
  output logic              running
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               step_q, step_d;
  logic [TICK_W-1:0]        tick_cnt_q, tick_cnt_d;
  logic                     gate_q, gate_d;
  logic                     strobe_q, strobe_d;
  logic [15:0][NOTE_W-1:0]  pat_note_q;
  logic [15:0]              pat_on_q;

  logic [TICK_W-1:0]        div_m1;
  logic [3:0]               adv_step;
  logic                     on_next;

  // tick_div of 0 behaves as 1, so the terminal count is clamped at 0.
  assign div_m1 = (tick_div == '0) ? '0 : tick_div - TICK_W'(1);

`ifdef SEQ_PINGPONG_EN
  logic dir_q, dir_d, dir_adv;  // 1 = moving backward

  always_comb begin
    adv_step = step_q;
    dir_adv  = dir_q;
    if (len_m1 == 4'd0) begin
      adv_step = 4'd0;
      dir_adv  = 1'b0;
    end else if (!dir_q) begin
      if (step_q >= len_m1) begin
        adv_step = len_m1 - 4'd1;
        dir_adv  = 1'b1;
      end else begin
        adv_step = step_q + 4'd1;
      end
    end else if (step_q == 4'd0) begin
      adv_step = 4'd1;
      dir_adv  = 1'b0;
    end else begin
      adv_step = step_q - 4'd1;
    end
  end
`else
  always_comb begin
    adv_step = (step_q >= len_m1) ? 4'd0 : step_q + 4'd1;
  end
`endif

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tick_cnt_d = tick_cnt_q;
    strobe_d   = 1'b0;
`ifdef SEQ_PINGPONG_EN
    dir_d      = dir_q;
`endif
    if (stop) begin
      state_d    = StIdle;
      step_d     = 4'd0;
      tick_cnt_d = '0;
`ifdef SEQ_PINGPONG_EN
      dir_d      = 1'b0;
`endif
    end else if (start) begin
      state_d    = StRun;
      step_d     = 4'd0;
      tick_cnt_d = '0;
      strobe_d   = 1'b1;
`ifdef SEQ_PINGPONG_EN
      dir_d      = 1'b0;
`endif
    end else if (state_q == StRun) begin
      // >= keeps the counter bounded if tick_div is lowered mid-step.
      if (tick_cnt_q >= div_m1) begin
        tick_cnt_d = '0;
        step_d     = adv_step;
        strobe_d   = 1'b1;
`ifdef SEQ_PINGPONG_EN
        dir_d      = dir_adv;
`endif
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
    end

    // Gate reflects the pattern as it will be after this edge's write.
    on_next = (wr_en && (wr_addr == step_d)) ? wr_on : pat_on_q[step_d];
    gate_d  = (state_d == StRun) && on_next && (tick_cnt_d < gate_len);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      step_q     <= 4'd0;
      tick_cnt_q <= '0;
      gate_q     <= 1'b0;
      strobe_q   <= 1'b0;
      pat_note_q <= '0;
      pat_on_q   <= '0;
`ifdef SEQ_PINGPONG_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      tick_cnt_q <= tick_cnt_d;
      gate_q     <= gate_d;
      strobe_q   <= strobe_d;
`ifdef SEQ_PINGPONG_EN
      dir_q      <= dir_d;
`endif
      if (wr_en) begin
        pat_note_q[wr_addr] <= wr_note;
        pat_on_q[wr_addr]   <= wr_on;
      end
    end
  end

  assign note        = pat_note_q[step_q];
  assign gate        = gate_q;
  assign step        = step_q;
  assign step_strobe = strobe_q;
  assign running     = (state_q == StRun);

endmodule
